// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU with iterative shift-add multiplier
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_MULH = 4'd12;

   localparam logic [WIDTH:0]  AMT_LIMIT = (WIDTH+1)'(WIDTH);
   localparam logic [CW-1:0]   LAST_BIT  = CW'(WIDTH-1);

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [3:0]         flags_q, flags_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               mulh_q, mulh_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      count_q, count_d;

   logic               take;
   logic               is_mul_op;
   logic [WIDTH:0]     sum, diff, shl_ext, shr_ext;
   logic [WIDTH-1:0]   sra_res, alu_r;
   logic               alu_c, alu_v, amt_ok;
   logic [3:0]         alu_flags;
   logic [2*WIDTH-1:0] pp, acc_sum;
   logic [WIDTH-1:0]   mul_r;
   logic [3:0]         mul_flags;

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign take      = in_valid && in_ready;
   assign is_mul_op = (sel == OP_MUL) || (sel == OP_MULH);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_MUL);
   assign result    = result_q;
   assign flags     = flags_q;

   // Single-cycle datapath: result and {V,C,N,Z} straight from the live inputs
   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      // Extra bit above/below the operand catches the last bit shifted out
      shl_ext = {1'b0, a} << b;
      shr_ext = {a, 1'b0} >> b;
      sra_res = $unsigned($signed(a) >>> b);
      amt_ok  = (b != '0) && ({1'b0, b} < AMT_LIMIT);
      alu_r   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (sel)
         4'd0: begin
            alu_r = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
         end
         4'd1: begin
            alu_r = diff[WIDTH-1:0];
            alu_c = diff[WIDTH];
            alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
         end
         4'd2: alu_r = a & b;
         4'd3: alu_r = a | b;
         4'd4: alu_r = a ^ b;
         4'd5: alu_r = ~a;
         4'd6: begin
            alu_r = {a[WIDTH-2:0], 1'b0};
            alu_c = a[WIDTH-1];
         end
         4'd7: begin
            alu_r = {1'b0, a[WIDTH-1:1]};
            alu_c = a[0];
         end
         4'd8: begin
            alu_r = shl_ext[WIDTH-1:0];
            alu_c = amt_ok && shl_ext[WIDTH];
         end
         4'd9: begin
            alu_r = shr_ext[WIDTH:1];
            alu_c = amt_ok && shr_ext[0];
         end
         4'd10: begin
            alu_r = sra_res;
            alu_c = amt_ok && shr_ext[0];
         end
         default: alu_r = '0;
      endcase
      alu_flags = {alu_v, alu_c, alu_r[WIDTH-1], (alu_r == '0)};
   end

   // Multiplier step: add the current partial product, select low or high half
   always_comb begin
      pp        = {{WIDTH{1'b0}}, a_q} << count_q;
      acc_sum   = b_q[count_q] ? (acc_q + pp) : acc_q;
      mul_r     = mulh_q ? acc_sum[2*WIDTH-1:WIDTH] : acc_sum[WIDTH-1:0];
      mul_flags = {1'b0, (acc_sum[2*WIDTH-1:WIDTH] != '0), mul_r[WIDTH-1], (mul_r == '0)};
   end

   // Control FSM: IDLE accepts, MUL iterates one bit per cycle, DONE holds the result
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      a_d      = a_q;
      b_d      = b_q;
      mulh_d   = mulh_q;
      acc_d    = acc_q;
      count_d  = count_q;
      case (state_q)
         ST_IDLE: ;
         ST_MUL: begin
            acc_d   = acc_sum;
            count_d = count_q + 1'b1;
            if (count_q == LAST_BIT) begin
               result_d = mul_r;
               flags_d  = mul_flags;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A transfer in DONE overrides the return to IDLE (back-to-back issue)
      if (take) begin
         if (is_mul_op) begin
            a_d     = a;
            b_d     = b;
            mulh_d  = (sel == OP_MULH);
            acc_d   = '0;
            count_d = '0;
            state_d = ST_MUL;
         end else begin
            result_d = alu_r;
            flags_d  = alu_flags;
            state_d  = ST_DONE;
         end
      end
   end

   // State registers with synchronous reset; reset drops any pending result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         flags_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         mulh_q   <= 1'b0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mulh_q   <= mulh_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu
module tb_seq_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic [3:0] sel;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [3:0] flags;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] r;
      logic [3:0] f;
      int         due;
      bit         mul;
   } exp_t;

   exp_t q[$];
   logic [7:0] bb[8] = '{8'h0D, 8'h07, 8'h02, 8'h0B, 8'h09, 8'hF5, 8'h14, 8'h05};

   seq_alu #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   // Reference: {V,C,N,Z, result} from integer arithmetic on 8-bit operands
   function automatic logic [11:0] model(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] s);
      int ua = av;
      int ub = bv;
      int sa = (av >= 128) ? int'(av) - 256 : int'(av);
      int sb = (bv >= 128) ? int'(bv) - 256 : int'(bv);
      int r = 0, c = 0, v = 0, p = 0;
      logic [7:0] rr;
      case (s)
         4'd0: begin p = ua + ub; r = p % 256; c = (p > 255); p = sa + sb; v = (p > 127 || p < -128); end
         4'd1: begin r = (ua - ub + 256) % 256; c = (ua < ub); p = sa - sb; v = (p > 127 || p < -128); end
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd5: r = 255 - ua;
         4'd6: begin r = (ua * 2) % 256; c = ua / 128; end
         4'd7: begin r = ua / 2; c = ua % 2; end
         4'd8: begin
            r = (ub >= 8) ? 0 : (ua << ub) % 256;
            c = (ub >= 1 && ub < 8) ? (ua >> (8 - ub)) & 1 : 0;
         end
         4'd9: begin
            r = (ub >= 8) ? 0 : ua >> ub;
            c = (ub >= 1 && ub < 8) ? (ua >> (ub - 1)) & 1 : 0;
         end
         4'd10: begin
            r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> ub) & 255;
            c = (ub >= 1 && ub < 8) ? (ua >> (ub - 1)) & 1 : 0;
         end
         4'd11: begin p = ua * ub; r = p % 256; c = (p >= 256); end
         4'd12: begin p = ua * ub; r = p / 256; c = (r != 0); end
         default: r = 0;
      endcase
      rr = r[7:0];
      return {v[0], c[0], rr[7], (rr == 8'h00), rr};
   endfunction

   // Cycle-by-cycle comparison against the queued expectations
   always @(negedge clk) begin
      bit ev;
      logic [11:0] m;
      cyc++;
      if (rst) begin
         q.delete();
      end else begin
         ev = (q.size() > 0) && (cyc >= q[0].due);
         chk("out_valid", out_valid, ev);
         chk("busy", busy, (q.size() > 0) && !ev && q[0].mul);
         chk("in_ready", in_ready, (q.size() == 0) || (ev && out_ready));
         if (ev && out_valid) begin
            chk("model result", result, q[0].r);
            chk("model flags", flags, q[0].f);
         end
         if (ev && out_ready) void'(q.pop_front());
         if (in_valid && in_ready) begin
            m = model(a, b, sel);
            q.push_back('{r: m[7:0], f: m[11:8],
                          due: cyc + ((sel == 4'd11 || sel == 4'd12) ? 9 : 1),
                          mul: (sel == 4'd11 || sel == 4'd12)});
         end
      end
   end

   task automatic run_op(input string nm, input logic [3:0] s, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] er, input logic [3:0] ef, input int elat);
      int k, lat, nb;
      @(posedge clk); #1;
      sel = s; a = av; b = bv; in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " accept"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      nb  = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) nb++;
      end while (!out_valid && lat < 40);
      chk({nm, " latency"}, lat, elat);
      chk({nm, " result"}, result, er);
      chk({nm, " flags"}, flags, ef);
      if (s == 4'd11 || s == 4'd12) chk({nm, " busy cycles"}, nb, 8);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sel = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset result", result, 0);
      chk("reset flags", flags, 0);
      chk("reset in_ready", in_ready, 1);

      // Legacy opcodes back-to-back, one result per cycle
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         sel = i[3:0]; a = 8'h0A; b = 8'h03; in_valid = 1'b1;
         @(negedge clk);
         chk("b2b in_ready", in_ready, 1);
         if (i > 0) chk("b2b result", result, bb[i-1]);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b last valid", out_valid, 1);
      chk("b2b last result", result, bb[7]);

      run_op("add carry",  4'd0,  8'hFF, 8'h01, 8'h00, 4'b0101, 1);
      run_op("add ovf",    4'd0,  8'h7F, 8'h01, 8'h80, 4'b1010, 1);
      run_op("sub borrow", 4'd1,  8'h03, 8'h0A, 8'hF9, 4'b0110, 1);
      run_op("mul",        4'd11, 8'h0F, 8'h11, 8'hFF, 4'b0010, 9);
      run_op("mulh",       4'd12, 8'hFF, 8'hFF, 8'hFE, 4'b0110, 9);
      run_op("sra 3",      4'd10, 8'h80, 8'h03, 8'hF0, 4'b0010, 1);
      run_op("shl 1",      4'd8,  8'h81, 8'h01, 8'h02, 4'b0100, 1);
      run_op("shl 0",      4'd8,  8'h81, 8'h00, 8'h81, 4'b0010, 1);
      run_op("shr 9",      4'd9,  8'hAA, 8'h09, 8'h00, 4'b0001, 1);
      run_op("reserved",   4'd14, 8'h5A, 8'h33, 8'h00, 4'b0001, 1);

      // Backpressure: result held, no new accepts
      @(posedge clk); #1;
      out_ready = 1'b0; sel = 4'd0; a = 8'h05; b = 8'h06; in_valid = 1'b1;
      @(negedge clk);
      chk("bp accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp valid", out_valid, 1);
         chk("bp result", result, 8'h0B);
         chk("bp flags", flags, 4'b0000);
         chk("bp in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp release valid", out_valid, 1);
      @(negedge clk);
      chk("bp drained valid", out_valid, 0);
      chk("bp idle in_ready", in_ready, 1);

      // Reset during the 4th MUL cycle
      @(posedge clk); #1;
      sel = 4'd11; a = 8'h03; b = 8'h05; in_valid = 1'b1;
      @(negedge clk);
      chk("rst mul accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort out_valid", out_valid, 0);
      chk("abort busy", busy, 0);
      chk("abort result", result, 0);
      run_op("post-reset add", 4'd0, 8'h01, 8'h01, 8'h02, 4'b0000, 1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the legacy 3-bit opcode set as opcodes 0–7 and adds variable shifts, arithmetic shift and an iterative shift-add multiplier. It registers result and status flags behind a valid/ready output port. It sits between an operand-issuing controller and a result consumer, with both sides using valid/ready flow control.

## Interface
- WIDTH, 8, operand/result width in bits (≥4, power of two)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount for opcodes 8–10)
- sel  in  4  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- flags  out  4  {V, C, N, Z}, registered with result
- busy  out  1  high in MUL state

## Operation
- Opcodes:
  - 0 ADD a+b; 1 SUB a−b; 2 AND; 3 OR; 4 XOR; 5 NOT a.
  - 6 a<<1; 7 a>>1 logical.
  - 8 SHL by b; 9 SHR logical by b; 10 SRA by b.
  - 11 MUL low half of a×b (unsigned); 12 MULH high half.
  - 13–15 reserved: result 0, flags {0,0,0,1}.
- The transfer occurs on any edge where in_valid && in_ready. a, b and sel are captured; input changes at other times are ignored.
- States: IDLE, MUL, DONE.
  - IDLE + transfer, opcode ≠ 11/12: compute, load result/flags, go to DONE.
  - IDLE + transfer, opcode 11/12: load the 2·WIDTH accumulator = 0, the count = 0, and go to MUL.
  - MUL: each cycle, if b_reg[count], add a_reg<<count to the accumulator; count++. At count == WIDTH−1, load result/flags and go to DONE.
  - DONE: out_valid = 1. If out_ready is high and there is no transfer, go to IDLE. If out_ready is high and a transfer occurs, behave as IDLE + transfer (back-to-back).
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Flags:
  - Z = (result == 0); N = result[WIDTH−1].
  - C for ADD: carry-out. For SUB: borrow (a < b unsigned). For shift-1/shift-n: the last bit shifted out; 0 if the amount is 0 or ≥ WIDTH. For MUL/MULH: 1 iff the high half ≠ 0. Otherwise 0.
  - V for ADD/SUB: two's-complement overflow. Otherwise 0.
- Shift amount is the full unsigned b. Amount ≥ WIDTH gives 0 for SHL/SHR, and WIDTH copies of a[WIDTH−1] for SRA.
- Arithmetic is modulo 2^WIDTH. Internal add/sub uses WIDTH+1 bits for carry.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, flags 0, busy 0, in_ready 1 (the cycle after reset deasserts).
- Reset mid-operation (MUL or DONE) aborts. No result is delivered, and the pending result is discarded.
- Single-cycle ops: out_valid is high the cycle after the accepting edge (latency 1). Throughput is 1 per cycle while out_ready stays high.
- MUL/MULH: out_valid rises WIDTH+1 edges after the accepting edge (9 for WIDTH=8). in_ready = 0 and busy = 1 throughout MUL.
- Backpressure: while out_valid && !out_ready, result and flags hold stable and in_ready = 0.
- out_valid deasserts on the edge after out_ready, unless a new single-cycle op is accepted on that same edge. In that case out_valid stays high and result updates.

## Test plan
- WIDTH=8, a=0x0A, b=0x03, out_ready=1, sel 0–7 back-to-back -> results 0x0D, 0x07, 0x02, 0x0B, 0x09, 0xF5, 0x14, 0x05. One result per cycle, in_ready held high.
- ADD 0xFF+0x01 -> 0x00, Z=1, C=1, V=0. ADD 0x7F+0x01 -> 0x80, N=1, V=1. SUB 0x03−0x0A -> 0xF9, C=1, N=1.
- MUL 0x0F×0x11 -> 0xFF, C=0, out_valid exactly 9 edges after accept, busy high 8 cycles. MULH 0xFF×0xFF -> 0xFE, C=1.
- Shifts:
  - SRA 0x80 by 3 -> 0xF0, C=0.
  - SHL 0x81 by 1 (opcode 8) -> 0x02, C=1.
  - SHR 0xAA by 9 -> 0x00, Z=1, C=0.
  - Opcode 14 -> 0x00, flags 0b0001.
- Backpressure: ADD accepted, out_ready=0 for 5 cycles -> result/flags constant, in_ready=0. Raise out_ready -> one transfer, then IDLE.
- rst=1 during the 4th MUL cycle -> next edge out_valid=0, busy=0, result=0. After release, ADD 1+1 is accepted and returns 0x02 with latency 1.
